timer_counter: RTL and testbench

Memory-mapped programmable timer/counter device on the CPU's peripheral side, downstream of the CPU's data-memory port through the address bridge. It exposes three 32-bit word registers: control, preset and count. It counts down from a preset value and raises an interrupt request to the CPU's exception/CP0 logic, either once or periodically depending on the mode.

---
 rtl/timer_pkg.sv | 38 +++
 rtl/timer_counter.sv | 136 +++++++++++++
 tb/tb_timer_counter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// timer_pkg -- shared constants for the timer_counter peripheral.
//
// Holds the FSM state encoding, the word offsets of the three registers,
// the bit positions inside CTRL and the MODE field values. Everything here
// is plain localparams so the encodings stay visible in waveforms and easy
// to bind checkers against.
package timer_pkg;

    // FSM state encoding (also driven out on dbg_state).
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_CNT  = 2'd2;
    localparam state_t ST_INT  = 2'd3;

    // Word offsets, taken from bus address [3:2].
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    // CTRL bit positions.
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // MODE field values; 2 and 3 fall back to one-shot behaviour.
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    // CTRL as seen by software: only the low four bits exist.
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/timer_counter.sv
// timer_counter -- memory-mapped down-counting timer with interrupt request.
//
// Three 32-bit word registers: CTRL (offset 0), PRESET (offset 1) and
// COUNT (offset 2, read-only). Offset 3 reads as zero and ignores writes.
// COUNT is loaded from PRESET and counts down to zero; on expiry an
// interrupt is raised once (MODE 0) or periodically (MODE 1).
//
// Bus protocol: there is no handshake. The bridge asserts `we` for exactly
// the cycles in which this device is selected for a write; the write takes
// effect on that rising edge. Reads are combinational from `addr` and show
// the register contents captured on the most recent edge.
//
// Ports:
//   clk        in   1   system clock, all state changes on the rising edge
//   reset      in   1   synchronous reset, active low
//   addr       in   2   word offset (bus address [3:2])
//   we         in   1   write strobe
//   din        in  32   write data
//   dout       out 32   read data, combinational from addr
//   irq        out  1   level interrupt request to CP0, registered
//   dbg_state  out  2   current FSM state (ST_* encoding), for debug/checkers
module timer_counter
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq,
    output logic [1:0]  dbg_state
);

    state_t      state, state_nxt;
    ctrl_t       ctrl, ctrl_nxt;
    logic [31:0] preset;
    logic [31:0] count, count_nxt;
    logic        irq_pend, irq_pend_nxt;

    logic        ctrl_wr;
    logic        preset_wr;

    assign ctrl_wr   = we && (addr == OFF_CTRL);
    assign preset_wr = we && (addr == OFF_PRESET);

    assign dbg_state = state;

    // Next-state logic: FSM first, then a software CTRL write overrides
    // both CTRL and irq_pend. That ordering is what makes a CTRL write in
    // the same cycle as the INT-state EN clear win for CTRL.
    always_comb begin
        state_nxt    = state;
        ctrl_nxt     = ctrl;
        count_nxt    = count;
        irq_pend_nxt = irq_pend;

        case (state)
            ST_IDLE: begin
                if (ctrl.en) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_nxt = preset;
                state_nxt = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl.en) begin
                    // COUNT holds so software can read where it stopped.
                    state_nxt = ST_IDLE;
                end else if (count > 32'd1) begin
                    count_nxt = count - 32'd1;
                end else begin
                    // Catching both 1 and 0 here means a PRESET of 0
                    // expires like 1 instead of wrapping.
                    count_nxt    = 32'd0;
                    irq_pend_nxt = 1'b1;
                    state_nxt    = ST_INT;
                end
            end
            ST_INT: begin
                if (ctrl.mode == MODE_RELOAD) begin
                    irq_pend_nxt = 1'b0;
                    state_nxt    = ST_LOAD;
                end else begin
                    // One-shot: irq_pend stays set until software writes CTRL.
                    ctrl_nxt.en = 1'b0;
                    state_nxt   = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (ctrl_wr) begin
            ctrl_nxt     = din[3:0];
            irq_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ctrl     <= '0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_pend <= 1'b0;
            irq      <= 1'b0;
        end else begin
            state    <= state_nxt;
            ctrl     <= ctrl_nxt;
            count    <= count_nxt;
            irq_pend <= irq_pend_nxt;
            if (preset_wr) begin
                preset <= din;
            end
            // A CTRL write in the cycle irq_pend is set acknowledges the
            // interrupt before the output register can pass it on, so the
            // pulse for that expiry never appears on irq.
            irq <= irq_pend && ctrl.im && !ctrl_wr;
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            OFF_CTRL:   dout = {28'd0, ctrl};
            OFF_PRESET: dout = preset;
            OFF_COUNT:  dout = count;
            default:    dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter -- directed bench for timer_counter.
// A per-cycle vector table covers the one-shot sequence; hand-written
// sequences cover reset, auto-reload, masking, stop, PRESET changes,
// PRESET = 0 and ignored offsets.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    timer_counter dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .we        (we),
        .din       (din),
        .dout      (dout),
        .irq       (irq),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        cyc();
        we   = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, dout, exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        din   = 32'd0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_irq;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic exp_b;

        reset = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        din   = 32'd0;

        // One-shot, PRESET = 5. Each row: inputs for one cycle and the
        // outputs seen during that cycle (state after the previous edge).
        // e0 = CTRL write; LOAD at e1; COUNT 5 at e2 ... 0 at e7; irq at e8.
        vecs[0]  = '{1'b1, 2'd1, 32'd5, 32'd0, 1'b0, 2'd0};  // PRESET <= 5
        vecs[1]  = '{1'b1, 2'd0, 32'h9, 32'd0, 1'b0, 2'd0};  // CTRL <= 9 (e0)
        vecs[2]  = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b0, 2'd0};  // after e0: IDLE
        vecs[3]  = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b0, 2'd1};  // after e1: LOAD
        vecs[4]  = '{1'b0, 2'd2, 32'd0, 32'd5, 1'b0, 2'd2};  // after e2
        vecs[5]  = '{1'b0, 2'd2, 32'd0, 32'd4, 1'b0, 2'd2};
        vecs[6]  = '{1'b0, 2'd2, 32'd0, 32'd3, 1'b0, 2'd2};
        vecs[7]  = '{1'b0, 2'd2, 32'd0, 32'd2, 1'b0, 2'd2};
        vecs[8]  = '{1'b0, 2'd2, 32'd0, 32'd1, 1'b0, 2'd2};  // after e6
        vecs[9]  = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b0, 2'd3};  // after e7: INT
        vecs[10] = '{1'b0, 2'd0, 32'd0, 32'h8, 1'b1, 2'd0};  // after e8: irq, EN cleared
        vecs[11] = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b1, 2'd0};  // irq stays high
        vecs[12] = '{1'b1, 2'd0, 32'h8, 32'h8, 1'b1, 2'd0};  // ack write
        vecs[13] = '{1'b0, 2'd0, 32'd0, 32'h8, 1'b0, 2'd0};  // irq low after ack
        vecs[14] = '{1'b0, 2'd3, 32'd0, 32'd0, 1'b0, 2'd0};  // offset 3 reads 0

        // ---- reset state ----
        do_reset();
        rd_check("reset ctrl",   2'd0, 32'd0);
        rd_check("reset preset", 2'd1, 32'd0);
        rd_check("reset count",  2'd2, 32'd0);
        rd_check("reset off3",   2'd3, 32'd0);
        check("reset irq",   {31'd0, irq}, 32'd0);
        check("reset state", {30'd0, dbg_state}, 32'd0);

        // ---- reset mid-count at COUNT = 3 ----
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        begin
            bit found;
            found = 1'b0;
            for (int n = 0; n < 40 && !found; n++) begin
                addr = 2'd2;
                #1;
                if (dout == 32'd3) found = 1'b1;
                else cyc();
            end
            check("midreset reach count3", {31'd0, found}, 32'd1);
        end
        reset = 1'b0;
        cyc();
        rd_check("midreset ctrl",   2'd0, 32'd0);
        rd_check("midreset preset", 2'd1, 32'd0);
        rd_check("midreset count",  2'd2, 32'd0);
        check("midreset state", {30'd0, dbg_state}, 32'd0);
        check("midreset irq",   {31'd0, irq}, 32'd0);
        reset = 1'b1;
        cyc();

        // ---- table: one-shot PRESET = 5 ----
        for (int i = 0; i < 15; i++) begin
            we   = vecs[i].we;
            addr = vecs[i].addr;
            din  = vecs[i].din;
            #3;
            check($sformatf("vec%0d dout", i),  dout, vecs[i].exp_dout);
            check($sformatf("vec%0d irq", i),   {31'd0, irq}, {31'd0, vecs[i].exp_irq});
            check($sformatf("vec%0d state", i), {30'd0, dbg_state}, {30'd0, vecs[i].exp_state});
            cyc();
        end
        we = 1'b0;

        // ---- auto-reload PRESET = 3: pulses every 5 cycles, one suppressed ----
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);                      // e0
        for (int k = 1; k <= 32; k++) begin
            cyc();
            we = 1'b0;
            exp_b = (k >= 6) && ((k - 6) % 5 == 0) && (k != 26);
            check($sformatf("reload irq k%0d", k), {31'd0, irq}, {31'd0, exp_b});
            if (k == 25) begin
                // Re-write CTRL while irq_pend is set: pulse at e26 suppressed.
                addr = 2'd0;
                din  = 32'hB;
                we   = 1'b1;
            end
        end

        // ---- masked interrupt: IM = 0 ----
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 7; k++) begin
            cyc();
            check($sformatf("masked irq k%0d", k), {31'd0, irq}, 32'd0);
        end
        rd_check("masked count", 2'd2, 32'd0);
        rd_check("masked ctrl en cleared", 2'd0, 32'd0);
        wr(2'd0, 32'h8);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("unmask irq c%0d", k), {31'd0, irq}, 32'd0);
            cyc();
        end

        // ---- stop mid-count ----
        do_reset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        begin
            bit found;
            found = 1'b0;
            for (int n = 0; n < 40 && !found; n++) begin
                addr = 2'd2;
                #1;
                if (dout == 32'd6) found = 1'b1;
                else cyc();
            end
            check("stop reach count6", {31'd0, found}, 32'd1);
        end
        wr(2'd0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            rd_check($sformatf("stop count hold c%0d", k), 2'd2, 32'd5);
            check($sformatf("stop irq c%0d", k), {31'd0, irq}, 32'd0);
            cyc();
        end
        check("stop state idle", {30'd0, dbg_state}, 32'd0);

        // ---- PRESET change during auto-reload ----
        do_reset();
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h3);                      // e0, MODE 1, IM 0
        begin
            logic [31:0] exp_cnt[13];
            exp_cnt = '{32'd0, 32'd0, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0,
                        32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd2};
            for (int k = 1; k <= 12; k++) begin
                cyc();
                we = 1'b0;
                rd_check($sformatf("reload preset k%0d", k), 2'd2, exp_cnt[k]);
                if (k == 3) begin
                    addr = 2'd1;
                    din  = 32'd2;
                    we   = 1'b1;
                end
            end
        end
        rd_check("reload new preset", 2'd1, 32'd2);

        // ---- PRESET = 0 expires like PRESET = 1 ----
        do_reset();
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            exp_b = (k >= 4);
            check($sformatf("preset0 irq k%0d", k), {31'd0, irq}, {31'd0, exp_b});
            if (k == 2) rd_check("preset0 count k2", 2'd2, 32'd0);
        end

        // ---- writes to offsets 2 and 3 are ignored ----
        wr(2'd1, 32'd7);
        wr(2'd2, 32'hDEAD_BEEF);
        wr(2'd3, 32'hFFFF_FFF7);
        rd_check("ignored count",  2'd2, 32'd0);
        rd_check("ignored preset", 2'd1, 32'd7);
        rd_check("ignored ctrl",   2'd0, 32'h8);
        rd_check("ignored off3",   2'd3, 32'd0);
        check("ignored irq still high", {31'd0, irq}, 32'd1);

        // ---- report ----
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
